spectral_peak_picker: RTL and testbench
=======================================

// Module: spectral_peak_picker
// PURPOSE
// - Magnitude-readout end of FFT_IMPLEMENTATION. Drives the bin index, consumes magnitude/magnitude_ready.
// - Scans the non-mirrored half of the spectrum (bins 0..FFT_LENGTH/2-1).
// - Keeps the strongest bin per equal-width frequency band, then emits one peak record per band
//   over a valid/ready stream. This is the fingerprint source for the hash stage.
// PARAMETERS
// - FFT_LENGTH  1024  points per FFT frame; power of two
// - MAG_WIDTH   16    magnitude width, unsigned
// - BAND_COUNT  4     number of bands; power of two, <= FFT_LENGTH/2
// - Derived: IDX_W = log2(FFT_LENGTH); BAND_SIZE = FFT_LENGTH/(2*BAND_COUNT); BAND_W = max(1, log2(BAND_COUNT))
// PORTS
// - clk                in   1          single clock, rising edge
// - reset              in   1          asynchronous, active-low
// - start_i            in   1          level; sampled only in IDLE (tie to done_FFT)
// - index_o            out  IDX_W      bin index presented to FFT readout
// - magnitude_i        in   MAG_WIDTH  magnitude of bin index_o
// - magnitude_ready_i  in   1          magnitude_i valid for current index_o
// - peak_valid_o       out  1          peak record available
// - peak_ready_i       in   1          consumer accepts record
// - peak_band_o        out  BAND_W     band number of record
// - peak_bin_o         out  IDX_W      winning bin of band
// - peak_mag_o         out  MAG_WIDTH  winning magnitude
// - busy_o             out  1          high in SCAN or EMIT
// - frame_done_o       out  1          one-cycle pulse after last record accepted
// BEHAVIOUR
// - Reset (asynchronous, any state): state=IDLE. All outputs 0. Band registers cleared. Emit counter 0.
// - IDLE
//   - index_o=0.
//   - start_i=1 -> SCAN next cycle; band registers cleared on that edge.
// - SCAN
//   - Each cycle with magnitude_ready_i=1: sample = (index_o, magnitude_i); index_o increments.
//   - magnitude_ready_i=0: index_o holds; nothing sampled.
//   - Band of sample = index_o >> log2(BAND_SIZE).
//   - First bin of a band always loads that band's register.
//   - Later bins replace it only on strictly greater magnitude, so ties keep the lowest bin.
//   - Sample at index FFT_LENGTH/2-1 -> EMIT next cycle; index_o returns to 0.
//   - Bins >= FFT_LENGTH/2 are never requested.
// - EMIT
//   - peak_valid_o=1 from the first EMIT cycle; records go out band 0 .. BAND_COUNT-1.
//   - Transfer = peak_valid_o & peak_ready_i.
//   - While peak_ready_i=0: valid and data held stable.
//   - After a transfer the next band's record is presented the next cycle; back-to-back at 1 record/cycle.
//   - Transfer of last band -> IDLE; frame_done_o=1 for exactly that next cycle.
// - Latency: first record valid 1 cycle after the final bin is sampled.
// - start_i outside IDLE is ignored.
// - magnitude_ready_i in IDLE/EMIT is ignored.
// - If start_i is still high in IDLE after a frame, a new scan begins immediately.
// - Compare is unsigned MAG_WIDTH. No arithmetic growth.
// CONFIGURATION
// - PEAK_THRESHOLD_EN defined
//   - Adds port threshold_i (in, MAG_WIDTH).
//   - A sample is eligible only if magnitude_i >= threshold_i. Ineligible samples never load.
//   - Each band has a hit flag. First eligible sample loads; later eligible samples replace on strictly greater.
//   - Band with no eligible sample emits peak_bin_o=0, peak_mag_o=0. Record count is unchanged.
// - PEAK_THRESHOLD_EN undefined
//   - No threshold_i port. Every sample is eligible (first-bin-loads rule above).
// TESTING
// - T1 ramp: magnitude=bin, ready every cycle (N=1024, B=4)
//   -> records (0,127,127) (1,255,255) (2,383,383) (3,511,511).
//   -> First valid 513 cycles after start; frame_done pulse after 4th accept.
// - T2 ties: all magnitudes=5 -> bins 0,128,256,384, each mag 5.
// - T3 single spike at bin 200 = 0xFFFF, rest 1
//   -> band1 = (200,0xFFFF); other bands = first bin, mag 1.
// - T4 backpressure
//   - Stimulus: peak_ready_i low 10 cycles, then alternate 1/0; magnitude_ready_i random 50%.
//   - Response: data stable while stalled; index_o holds on ready gaps; 4 records in order; no bin skipped or repeated.
// - T5 reset low at bin 300 mid-SCAN
//   -> all outputs 0 asynchronously; busy_o=0.
//   -> Re-start with T1 data gives T1 results exactly.
// - T6 (PEAK_THRESHOLD_EN) threshold=1000, ramp data
//   -> bands 0..1 emit (0,0); band2 (383,383)? no, ineligible -> (0,0); band3 (0,0).
//   -> Repeat with magnitude=4*bin: band2 (383,1532), band3 (511,2044).

Source files
------------

// File: rtl/spectral_peak_picker.sv
// Per-band spectral peak picker: scans bins 0..FFT_LENGTH/2-1 and streams the strongest bin of each band.
// Optional feature macro PEAK_THRESHOLD_EN adds threshold_i; samples below it never load a band.
module spectral_peak_picker #(
  parameter int FFT_LENGTH = 1024,
  parameter int MAG_WIDTH  = 16,
  parameter int BAND_COUNT = 4,
  localparam int IDX_W     = $clog2(FFT_LENGTH),
  localparam int BAND_W    = (BAND_COUNT > 1) ? $clog2(BAND_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  output logic [IDX_W-1:0]     index_o,
  input  logic [MAG_WIDTH-1:0] magnitude_i,
  input  logic                 magnitude_ready_i,
  output logic                 peak_valid_o,
  input  logic                 peak_ready_i,
  output logic [BAND_W-1:0]    peak_band_o,
  output logic [IDX_W-1:0]     peak_bin_o,
  output logic [MAG_WIDTH-1:0] peak_mag_o,
  output logic                 busy_o,
  output logic                 frame_done_o
`ifdef PEAK_THRESHOLD_EN
  ,
  input  logic [MAG_WIDTH-1:0] threshold_i
`endif
);

  localparam int BAND_SIZE = FFT_LENGTH / (2 * BAND_COUNT);
  localparam int BAND_SH   = $clog2(BAND_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FFT_LENGTH / 2 - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(BAND_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       index_q;
  logic [BAND_W-1:0]      emit_q;
  logic [IDX_W-1:0]       band_bin_q [BAND_COUNT];
  logic [MAG_WIDTH-1:0]   band_mag_q [BAND_COUNT];
  logic [BAND_COUNT-1:0]  hit_q;
  logic [IDX_W-1:0]       band_bin_d [BAND_COUNT];
  logic [MAG_WIDTH-1:0]   band_mag_d [BAND_COUNT];
  logic [BAND_COUNT-1:0]  hit_d;
  logic                   valid_q;
  logic [BAND_W-1:0]      band_out_q;
  logic [IDX_W-1:0]       bin_out_q;
  logic [MAG_WIDTH-1:0]   mag_out_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   eligible_s;
  logic                   sample_s;
  logic                   load_s;
  logic [BAND_W-1:0]      band_sel_s;
  logic [BAND_W-1:0]      emit_nx_s;

`ifdef PEAK_THRESHOLD_EN
  assign eligible_s = (magnitude_i >= threshold_i);
`else
  assign eligible_s = 1'b1;
`endif

  // The hit flag makes the first eligible sample of a band load unconditionally;
  // afterwards only a strictly larger magnitude wins, so ties keep the lowest bin.
  assign band_sel_s = BAND_W'(index_q >> BAND_SH);
  assign sample_s   = (state_q == S_SCAN) && magnitude_ready_i;
  assign load_s     = sample_s && eligible_s &&
                      (!hit_q[band_sel_s] || (magnitude_i > band_mag_q[band_sel_s]));
  assign emit_nx_s  = emit_q + BAND_W'(1);

  assign index_o      = index_q;
  assign peak_valid_o = valid_q;
  assign peak_band_o  = band_out_q;
  assign peak_bin_o   = bin_out_q;
  assign peak_mag_o   = mag_out_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

  // Next-state of the per-band best-so-far registers for the current sample.
  always_comb begin
    band_bin_d = band_bin_q;
    band_mag_d = band_mag_q;
    hit_d      = hit_q;
    if (load_s) begin
      band_bin_d[band_sel_s] = index_q;
      band_mag_d[band_sel_s] = magnitude_i;
      hit_d[band_sel_s]      = 1'b1;
    end else begin
      hit_d = hit_q;
    end
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      emit_q     <= '0;
      hit_q      <= '0;
      valid_q    <= 1'b0;
      band_out_q <= '0;
      bin_out_q  <= '0;
      mag_out_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int b = 0; b < BAND_COUNT; b++) begin
        band_bin_q[b] <= '0;
        band_mag_q[b] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          index_q <= '0;
          if (start_i) begin
            state_q <= S_SCAN;
            busy_q  <= 1'b1;
            emit_q  <= '0;
            hit_q   <= '0;
            for (int b = 0; b < BAND_COUNT; b++) begin
              band_bin_q[b] <= '0;
              band_mag_q[b] <= '0;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SCAN: begin
          band_bin_q <= band_bin_d;
          band_mag_q <= band_mag_d;
          hit_q      <= hit_d;
          if (sample_s) begin
            if (index_q == LAST_IDX) begin
              // Band 0 may still be updating on this very sample, so take the _d view.
              state_q    <= S_EMIT;
              index_q    <= '0;
              emit_q     <= '0;
              valid_q    <= 1'b1;
              band_out_q <= '0;
              bin_out_q  <= band_bin_d[0];
              mag_out_q  <= band_mag_d[0];
            end else begin
              index_q <= index_q + IDX_W'(1);
            end
          end else begin
            index_q <= index_q;
          end
        end
        S_EMIT: begin
          if (valid_q && peak_ready_i) begin
            if (emit_q == LAST_BAND) begin
              state_q    <= S_IDLE;
              valid_q    <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              emit_q     <= '0;
              band_out_q <= '0;
              bin_out_q  <= '0;
              mag_out_q  <= '0;
            end else begin
              emit_q     <= emit_nx_s;
              band_out_q <= emit_nx_s;
              bin_out_q  <= band_bin_q[emit_nx_s];
              mag_out_q  <= band_mag_q[emit_nx_s];
            end
          end else begin
            valid_q <= valid_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          index_q <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectral_peak_picker.sv
// Self-checking bench for spectral_peak_picker: per-band max model, per-cycle compare, directed frames.
`timescale 1ns/1ps
module tb_spectral_peak_picker;
  localparam int N    = 1024;
  localparam int MW   = 16;
  localparam int BC   = 4;
  localparam int IW   = 10;
  localparam int BW   = 2;
  localparam int HALF = N / 2;
  localparam int BS   = HALF / BC;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [IW-1:0] index_o;
  logic [MW-1:0] magnitude_i;
  logic          magnitude_ready_i;
  logic          peak_valid_o;
  logic          peak_ready_i;
  logic [BW-1:0] peak_band_o;
  logic [IW-1:0] peak_bin_o;
  logic [MW-1:0] peak_mag_o;
  logic          busy_o;
  logic          frame_done_o;
  logic [MW-1:0] threshold_i;

  spectral_peak_picker #(.FFT_LENGTH(N), .MAG_WIDTH(MW), .BAND_COUNT(BC)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .index_o(index_o),
    .magnitude_i(magnitude_i), .magnitude_ready_i(magnitude_ready_i),
    .peak_valid_o(peak_valid_o), .peak_ready_i(peak_ready_i),
    .peak_band_o(peak_band_o), .peak_bin_o(peak_bin_o), .peak_mag_o(peak_mag_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
`ifdef PEAK_THRESHOLD_EN
    , .threshold_i(threshold_i)
`endif
  );

  always #5 clk = ~clk;

  logic [MW-1:0] frame_mag [HALF];
  logic [IW-1:0] exp_bin [BC];
  logic [MW-1:0] exp_mag [BC];
  logic [IW-1:0] got_bin [BC];
  logic [MW-1:0] got_mag [BC];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int rec_idx = 0;
  int exp_idx = 0;
  bit done_exp = 1'b0;
  bit prev_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: per band, the largest eligible magnitude, then the lowest bin holding it.
  task automatic build_model(input logic [MW-1:0] th);
    for (int b = 0; b < BC; b++) begin
      int mx;
      mx = -1;
      for (int k = b * BS; k < (b + 1) * BS; k++)
        if (frame_mag[k] >= th && int'(frame_mag[k]) > mx) mx = int'(frame_mag[k]);
      exp_bin[b] = '0;
      exp_mag[b] = '0;
      if (mx >= 0) begin
        for (int k = (b + 1) * BS - 1; k >= b * BS; k--)
          if (frame_mag[k] >= th && int'(frame_mag[k]) == mx) exp_bin[b] = IW'(k);
        exp_mag[b] = MW'(mx);
      end
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("frame_done", frame_done_o, done_exp);
      done_exp = 1'b0;
      if (prev_stall) check("stall_valid_hold", peak_valid_o, 1);
      prev_stall = 1'b0;
      if (peak_valid_o) begin
        check("busy_in_emit", busy_o, 1);
        if (rec_idx < BC) begin
          check("rec_band", peak_band_o, rec_idx);
          check("rec_bin", peak_bin_o, exp_bin[rec_idx]);
          check("rec_mag", peak_mag_o, exp_mag[rec_idx]);
          got_bin[rec_idx] = peak_bin_o;
          got_mag[rec_idx] = peak_mag_o;
        end else begin
          check("extra_record", rec_idx, BC - 1);
        end
        if (peak_ready_i) begin
          done_exp = (rec_idx == BC - 1);
          rec_idx++;
        end else begin
          prev_stall = 1'b1;
        end
      end else if (busy_o) begin
        if (magnitude_ready_i) begin
          check("scan_index", index_o, exp_idx);
          exp_idx++;
        end
      end else begin
        check("idle_index", index_o, 0);
      end
    end
  end

  // mode 0: all ready; mode 1: backpressure + random magnitude_ready. abort_at >= 0 stops mid-scan.
  task automatic run_frame(input int mode, input int abort_at, input logic [MW-1:0] th,
                           output int first_valid, output bit aborted);
    int n;
    bit fin;
    build_model(th);
    threshold_i = th;
    rec_idx = 0; exp_idx = 0; done_exp = 1'b0; prev_stall = 1'b0;
    for (int b = 0; b < BC; b++) begin got_bin[b] = '1; got_mag[b] = '1; end
    chk_en = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b1;
    magnitude_ready_i = 1'b1;
    peak_ready_i = (mode == 0);
    n = 0; fin = 1'b0; first_valid = -1; aborted = 1'b0;
    while (!fin && n < 4000) begin
      @(posedge clk); #1;
      n++;
      start_i = 1'b0;
      if (abort_at >= 0 && busy_o && int'(index_o) == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (peak_valid_o && first_valid < 0) first_valid = n;
      if (frame_done_o) fin = 1'b1;
      magnitude_i = (int'(index_o) < HALF) ? frame_mag[int'(index_o)] : '0;
      magnitude_ready_i = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      if (mode == 1 && first_valid >= 0)
        peak_ready_i = ((n - first_valid) < 10) ? 1'b0 : ((n - first_valid) % 2 == 0);
    end
    if (abort_at < 0) begin
      check("frame_completes", fin, 1);
      check("records_emitted", rec_idx, BC);
      check("bins_scanned", exp_idx, HALF);
      @(negedge clk); #1;
    end
  endtask

  task automatic check_got(input string name, input int b, input int bin, input int mag);
    check({name, "_bin"}, got_bin[b], bin);
    check({name, "_mag"}, got_mag[b], mag);
  endtask

  initial begin
    int fv;
    bit ab;
    reset = 1'b0; start_i = 1'b0; magnitude_i = '0; magnitude_ready_i = 1'b0;
    peak_ready_i = 1'b0; threshold_i = '0;
    #12;
    check("rst_valid", peak_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_index", index_o, 0);
    check("rst_bin", peak_bin_o, 0);
    check("rst_mag", peak_mag_o, 0);
    check("rst_done", frame_done_o, 0);
    #10 reset = 1'b1;

    // T1 ramp
    for (int k = 0; k < HALF; k++) frame_mag[k] = MW'(k);
    run_frame(0, -1, '0, fv, ab);
    check("t1_latency", fv, 513);
    check("t1_model_bin3", exp_bin[3], 511);
    for (int b = 0; b < BC; b++) check_got("t1", b, 127 + 128 * b, 127 + 128 * b);

    // T2 ties
    for (int k = 0; k < HALF; k++) frame_mag[k] = 16'd5;
    run_frame(0, -1, '0, fv, ab);
    for (int b = 0; b < BC; b++) check_got("t2", b, 128 * b, 5);

    // T3 single spike
    for (int k = 0; k < HALF; k++) frame_mag[k] = 16'd1;
    frame_mag[200] = 16'hFFFF;
    run_frame(0, -1, '0, fv, ab);
    check("t3_model_bin1", exp_bin[1], 200);
    check_got("t3_b0", 0, 0, 1);
    check_got("t3_b1", 1, 200, 16'hFFFF);
    check_got("t3_b2", 2, 256, 1);
    check_got("t3_b3", 3, 384, 1);

    // T4 backpressure with random small magnitudes (plenty of ties)
    for (int k = 0; k < HALF; k++) frame_mag[k] = MW'($urandom_range(0, 15));
    run_frame(1, -1, '0, fv, ab);

    // T5 asynchronous reset mid-scan, then T1 again
    for (int k = 0; k < HALF; k++) frame_mag[k] = MW'(k);
    run_frame(0, 300, '0, fv, ab);
    check("t5_reached_300", ab, 1);
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t5_valid", peak_valid_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_index", index_o, 0);
    check("t5_bin", peak_bin_o, 0);
    check("t5_mag", peak_mag_o, 0);
    check("t5_done", frame_done_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    magnitude_ready_i = 1'b0;
    run_frame(0, -1, '0, fv, ab);
    check("t5_latency", fv, 513);
    for (int b = 0; b < BC; b++) check_got("t5", b, 127 + 128 * b, 127 + 128 * b);

`ifdef PEAK_THRESHOLD_EN
    // T6 threshold
    run_frame(0, -1, 16'd1000, fv, ab);
    for (int b = 0; b < BC; b++) check_got("t6a", b, 0, 0);
    for (int k = 0; k < HALF; k++) frame_mag[k] = MW'(4 * k);
    run_frame(0, -1, 16'd1000, fv, ab);
    check_got("t6b_b0", 0, 0, 0);
    check_got("t6b_b2", 2, 383, 1532);
    check_got("t6b_b3", 3, 511, 2044);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
